// File: rtl/modexp_sequencer.sv
// Right-to-left square-and-multiply sequencer driving one external modmult engine.
// Optional engine watchdog enabled by defining MODEXP_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module modexp_sequencer #(
  parameter int WIDTH          = 32,
  parameter int EXP_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0]     mod_in,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result_out,
  output logic                 mm_ready,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  // state    | meaning
  // IDLE     | waiting for start; done pulse is cleared here
  // CHECK    | screen n and e for trivial results, else issue the first transaction
  // MUL_WAIT | engine computing acc*sq mod n
  // SQR_WAIT | engine computing sq*sq mod n
  // GAP      | one cycle with mm_ready low; shift e after a square and issue the next request
  // FIN      | pulse done, drop busy
  // The bit-select step is folded into CHECK and GAP so no cycle is spent on it.
  typedef enum logic [2:0] {
    IDLE, CHECK, MUL_WAIT, SQR_WAIT, GAP, FIN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t               state;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     sq;
  logic [WIDTH-1:0]     n;
  logic [EXP_WIDTH-1:0] e;
  logic [EXP_WIDTH-1:0] e_shr;
  logic                 last_mul;
  logic                 tmo_hit;

  assign e_shr = e >> 1;

`ifdef MODEXP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Reloaded whenever not waiting; reaching zero in the last wait cycle lands done on the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != MUL_WAIT && state != SQR_WAIT) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 2);
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      sq         <= '0;
      n          <= '0;
      e          <= '0;
      last_mul   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      result_out <= '0;
      mm_ready   <= 1'b0;
      mm_a       <= '0;
      mm_b       <= '0;
      mm_n       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sq    <= base_in;
            e     <= exp_in;
            n     <= mod_in;
            mm_n  <= mod_in;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (n == '0) begin
            result_out <= '0;
            error      <= 1'b1;
            state      <= FIN;
          end else if (n == ONE) begin
            result_out <= '0;
            state      <= FIN;
          end else if (e == '0) begin
            result_out <= ONE;
            state      <= FIN;
          end else begin
            acc      <= ONE;
            mm_ready <= 1'b1;
            if (e[0]) begin
              mm_a     <= ONE;
              mm_b     <= sq;
              last_mul <= 1'b1;
              state    <= MUL_WAIT;
            end else begin
              mm_a     <= sq;
              mm_b     <= sq;
              last_mul <= 1'b0;
              state    <= SQR_WAIT;
            end
          end
        end

        MUL_WAIT, SQR_WAIT: begin
          if (mm_done) begin
            if (state == MUL_WAIT) acc <= mm_result;
            else                   sq  <= mm_result;
            mm_ready <= 1'b0;
            state    <= GAP;
          end else if (tmo_hit) begin
            // Watchdog exit skips FIN so done lands exactly on the limit.
            mm_ready   <= 1'b0;
            result_out <= '0;
            error      <= 1'b1;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        GAP: begin
          if (last_mul) begin
            if (e_shr != '0) begin
              mm_a     <= sq;
              mm_b     <= sq;
              mm_ready <= 1'b1;
              last_mul <= 1'b0;
              state    <= SQR_WAIT;
            end else begin
              result_out <= acc;
              state      <= FIN;
            end
          end else begin
            // e_shr is nonzero here: a square is only issued below the top set bit.
            e        <= e_shr;
            mm_ready <= 1'b1;
            if (e_shr[0]) begin
              mm_a     <= acc;
              mm_b     <= sq;
              last_mul <= 1'b1;
              state    <= MUL_WAIT;
            end else begin
              mm_a     <= sq;
              mm_b     <= sq;
              last_mul <= 1'b0;
              state    <= SQR_WAIT;
            end
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: 5-cycle modmult stub, arithmetic reference model, randomized runs.
module tb_modexp_sequencer;
  localparam int W         = 32;
  localparam int EW        = 32;
  localparam int TMO       = 16;
  localparam int STUB_LAT  = 5;
  localparam int LAT_LIMIT = 5000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  base_in = '0;
  logic [EW-1:0] exp_in = '0;
  logic [W-1:0]  mod_in = '0;
  logic          busy, done, error, mm_ready, mm_done;
  logic [W-1:0]  result_out, mm_a, mm_b, mm_n, mm_result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  modexp_sequencer #(.WIDTH(W), .EXP_WIDTH(EW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_in(base_in), .exp_in(exp_in),
    .mod_in(mod_in), .busy(busy), .done(done), .error(error), .result_out(result_out),
    .mm_ready(mm_ready), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  // modmult stub: mm_done rises in the STUB_LAT-th cycle of mm_ready
  int           stub_cnt;
  bit           stub_en = 1'b1;
  logic         stub_done;
  logic [W-1:0] stub_result;
  logic         spur = 1'b0;

  assign mm_done   = stub_done | spur;
  assign mm_result = spur ? 32'hDEAD_BEEF : stub_result;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_cnt <= 0; stub_done <= 1'b0; stub_result <= '0;
    end else if (mm_ready && !stub_done && stub_en) begin
      if (stub_cnt == STUB_LAT - 2) begin
        stub_done   <= 1'b1;
        stub_result <= W'((64'(mm_a) * 64'(mm_b)) % 64'(mm_n));
        stub_cnt    <= 0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end else begin
      stub_done <= 1'b0; stub_cnt <= 0;
    end
  end

  // request monitor: counts mm_ready rising edges and operand changes during a request
  int           ready_edges = 0;
  int           stable_viol = 0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] pa, pb, pn, last_a, last_b, last_n;

  always @(posedge clk) begin
    if (mm_ready && !prev_ready) begin
      ready_edges++;
      last_a = mm_a; last_b = mm_b; last_n = mm_n;
    end else if (mm_ready && prev_ready && (mm_a !== pa || mm_b !== pb || mm_n !== pn)) begin
      stable_viol++;
    end
    prev_ready = mm_ready;
    pa = mm_a; pb = mm_b; pn = mm_n;
  end

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] ex,
                                             input logic [31:0] m);
    longint unsigned r, x, mm;
    logic [31:0] k;
    if (m <= 1) return 32'd0;
    mm = 64'(m); r = 1; x = 64'(b) % mm; k = ex;
    while (k != 0) begin
      if (k[0]) r = (r * x) % mm;
      x = (x * x) % mm;
      k = k >> 1;
    end
    return 32'(r);
  endfunction

  function automatic int ref_tx(input logic [31:0] ex, input logic [31:0] m);
    int msb;
    if (m <= 1 || ex == 0) return 0;
    msb = 0;
    for (int i = 0; i < 32; i++) if (ex[i]) msb = i;
    return $countones(ex) + msb;
  endfunction

  function automatic int ref_lat(input int tx);
    return 3 + tx * (STUB_LAT + 1);
  endfunction

  task automatic run_op(input logic [31:0] b, input logic [31:0] ex, input logic [31:0] m,
                        output logic [31:0] res, output logic err, output int lat,
                        output int tx, output logic busy1);
    int e0;
    e0 = ready_edges;
    @(negedge clk);
    base_in = b; exp_in = ex; mod_in = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; busy1 = busy;
    while (!done && lat < LAT_LIMIT) begin
      @(posedge clk); #1; lat++;
    end
    res = result_out; err = error; tx = ready_edges - e0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, error, result_out, mm_ready, mm_a, mm_b, mm_n} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b error=%b result=%0d mm_ready=%b a=%0d b=%0d n=%0d want all 0",
               busy, done, error, result_out, mm_ready, mm_a, mm_b, mm_n);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_case1();
    logic [31:0] res; logic err, b1; int lat, tx;
    run_op(32'd4, 32'd13, 32'd497, res, err, lat, tx, b1);
    total++; if (res !== ref_modexp(4, 13, 497)) begin bad++; $display("FAIL case1_result: got %0d want %0d", res, ref_modexp(4, 13, 497)); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL case1_error: got %b want 0", err); end
    total++; if (tx !== ref_tx(13, 497)) begin bad++; $display("FAIL case1_requests: got %0d want %0d", tx, ref_tx(13, 497)); end
    total++; if (lat !== ref_lat(ref_tx(13, 497))) begin bad++; $display("FAIL case1_latency: got %0d want %0d", lat, ref_lat(ref_tx(13, 497))); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL case1_busy: got %b want 1", b1); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL case1_done_pulse: got %b want 0", done); end
    total++; if (result_out !== ref_modexp(4, 13, 497)) begin bad++; $display("FAIL case1_result_hold: got %0d want %0d", result_out, ref_modexp(4, 13, 497)); end
  endtask

  task automatic test_single_mul();
    logic [31:0] res; logic err, b1; int lat, tx;
    run_op(32'd524, 32'd1, 32'd31, res, err, lat, tx, b1);
    total++; if (res !== ref_modexp(524, 1, 31)) begin bad++; $display("FAIL mul_result: got %0d want %0d", res, ref_modexp(524, 1, 31)); end
    total++; if (tx !== 1) begin bad++; $display("FAIL mul_requests: got %0d want 1", tx); end
    total++; if ({last_a, last_b, last_n} !== {32'd1, 32'd524, 32'd31}) begin
      bad++; $display("FAIL mul_operands: got a=%0d b=%0d n=%0d want a=1 b=524 n=31", last_a, last_b, last_n);
    end
    total++; if (lat !== ref_lat(1)) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat, ref_lat(1)); end
  endtask

  task automatic test_trivial();
    logic [31:0] tb_b[3] = '{32'd9, 32'd9, 32'd9};
    logic [31:0] tb_e[3] = '{32'd0, 32'd5, 32'd5};
    logic [31:0] tb_m[3] = '{32'd31, 32'd1, 32'd0};
    logic [31:0] res; logic err, b1; int lat, tx;
    for (int i = 0; i < 3; i++) begin
      run_op(tb_b[i], tb_e[i], tb_m[i], res, err, lat, tx, b1);
      total++; if (res !== ref_modexp(tb_b[i], tb_e[i], tb_m[i])) begin bad++; $display("FAIL trivial%0d_result: got %0d want %0d", i, res, ref_modexp(tb_b[i], tb_e[i], tb_m[i])); end
      total++; if (err !== (tb_m[i] == 0)) begin bad++; $display("FAIL trivial%0d_error: got %b want %b", i, err, tb_m[i] == 0); end
      total++; if (tx !== 0) begin bad++; $display("FAIL trivial%0d_requests: got %0d want 0", i, tx); end
      total++; if (lat !== 3) begin bad++; $display("FAIL trivial%0d_latency: got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_spurious_done();
    logic [31:0] res; logic err, b1; int lat, tx;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    run_op(32'd5, 32'd3, 32'd31, res, err, lat, tx, b1);
    total++; if (res !== ref_modexp(5, 3, 31)) begin bad++; $display("FAIL spurious_result: got %0d want %0d", res, ref_modexp(5, 3, 31)); end
  endtask

  task automatic test_random();
    logic [31:0] b, ex, m, res; logic err, b1; int lat, tx;
    for (int i = 0; i < 24; i++) begin
      b  = $urandom;
      m  = (i % 3 == 0) ? 32'($urandom_range(2, 60)) : $urandom;
      if (m < 2) m = 2;
      ex = $urandom >> $urandom_range(0, 31);
      run_op(b, ex, m, res, err, lat, tx, b1);
      total++;
      if (res !== ref_modexp(b, ex, m) || err !== 1'b0 || tx !== ref_tx(ex, m) || lat !== ref_lat(ref_tx(ex, m))) begin
        bad++;
        $display("FAIL random%0d: b=%0d e=%0d n=%0d got res=%0d err=%b tx=%0d lat=%0d want res=%0d err=0 tx=%0d lat=%0d",
                 i, b, ex, m, res, err, tx, lat, ref_modexp(b, ex, m), ref_tx(ex, m), ref_lat(ref_tx(ex, m)));
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res; logic err, b1; int lat, tx;
    @(negedge clk);
    base_in = 32'd4; exp_in = 32'd13; mod_in = 32'd497; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat = 1;
    repeat (9) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    base_in = 32'd7; exp_in = 32'd3; mod_in = 32'd11; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; lat++;
    while (!done && lat < LAT_LIMIT) begin @(posedge clk); #1; lat++; end
    total++; if (result_out !== ref_modexp(4, 13, 497)) begin bad++; $display("FAIL busy_start_result: got %0d want %0d", result_out, ref_modexp(4, 13, 497)); end
    total++; if (lat !== ref_lat(ref_tx(13, 497))) begin bad++; $display("FAIL busy_start_latency: got %0d want %0d", lat, ref_lat(ref_tx(13, 497))); end
    run_op(32'd7, 32'd3, 32'd11, res, err, lat, tx, b1);
    total++; if (res !== ref_modexp(7, 3, 11) || lat !== ref_lat(ref_tx(3, 11))) begin
      bad++; $display("FAIL second_start: got res=%0d lat=%0d want res=%0d lat=%0d", res, lat, ref_modexp(7, 3, 11), ref_lat(ref_tx(3, 11)));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic err, b1; int lat, tx, e0, k;
    logic pre_ready;
    e0 = ready_edges;
    @(negedge clk);
    base_in = 32'd4; exp_in = 32'd13; mod_in = 32'd497; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; k = 0;
    while (ready_edges - e0 < 6 && k < LAT_LIMIT) begin @(posedge clk); #1; k++; end
    pre_ready = mm_ready;
    total++; if (pre_ready !== 1'b1 || ready_edges - e0 !== 6) begin
      bad++; $display("FAIL reset_mid_reach: got mm_ready=%b requests=%0d want 1 and 6", pre_ready, ready_edges - e0);
    end
    #1 reset = 1'b1;
    #1;
    total++; if ({mm_ready, busy, done} !== 3'b000) begin
      bad++; $display("FAIL reset_mid_outputs: got mm_ready=%b busy=%b done=%b want 0 0 0", mm_ready, busy, done);
    end
    @(negedge clk); reset = 1'b0;
    run_op(32'd4, 32'd13, 32'd497, res, err, lat, tx, b1);
    total++; if (res !== ref_modexp(4, 13, 497) || lat !== ref_lat(ref_tx(13, 497))) begin
      bad++; $display("FAIL reset_rerun: got res=%0d lat=%0d want res=%0d lat=%0d", res, lat, ref_modexp(4, 13, 497), ref_lat(ref_tx(13, 497)));
    end
  endtask

`ifdef MODEXP_TIMEOUT_EN
  task automatic test_timeout();
    int k, w;
    stub_en = 1'b0;
    @(negedge clk);
    base_in = 32'd5; exp_in = 32'd3; mod_in = 32'd31; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; k = 0;
    while (!mm_ready && k < 20) begin @(posedge clk); #1; k++; end
    w = 1;
    while (!done && w < 100) begin @(posedge clk); #1; w++; end
    total++; if (w !== TMO) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", w, TMO); end
    total++; if ({error, result_out, mm_ready} !== {1'b1, 32'd0, 1'b0}) begin
      bad++; $display("FAIL timeout_outputs: got error=%b result=%0d mm_ready=%b want 1 0 0", error, result_out, mm_ready);
    end
    stub_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_case1();
    test_single_mul();
    test_trivial();
    test_spurious_done();
    test_start_while_busy();
    test_reset_mid();
    test_random();
`ifdef MODEXP_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (stable_viol !== 0) begin bad++; $display("FAIL operand_stability: got %0d changes want 0", stable_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, got stuck want completion");
    $fatal(1, "global timeout");
  end
endmodule
